// File: rtl/mag_comp_seq.sv
// mag_comp_seq: sequential magnitude comparator.
// Compares two WIDTH-bit operands DIGIT bits per clock, most-significant digit
// first, behind a start/done handshake. When SIGNED=1 the top digit is compared
// as a two's-complement value; all lower digits are always compared unsigned.
//
// Optional feature macro: MAG_COMP_EARLY_EXIT_EN
//   defined   : the compare finishes on the edge that sees the first unequal digit.
//   undefined : constant time, always NDIG edges in CMP; flags are identical.
//
// Ports:
//   clk        in   rising-edge clock
//   rst_n      in   asynchronous active-low reset
//   start      in   request a compare (sampled only while idle)
//   a, b       in   WIDTH-bit operands, sampled with start
//   busy       out  compare in progress
//   done       out  one-cycle pulse, result flags valid
//   a_greater  out  A > B
//   b_greater  out  B > A
//   both_equal out  A == B
module mag_comp_seq #(
  parameter int unsigned WIDTH  = 8,
  parameter int unsigned DIGIT  = 1,
  parameter int unsigned SIGNED = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic             a_greater,
  output logic             b_greater,
  output logic             both_equal
);

  localparam int unsigned NDIG = WIDTH / DIGIT;
  localparam int unsigned IW   = (NDIG > 1) ? $clog2(NDIG) : 1;
  localparam logic [IW-1:0] IDX_MSD = IW'(NDIG - 1);

  typedef enum logic {ST_IDLE, ST_CMP} state_t;

  state_t           r_state, w_state_nx;
  logic [WIDTH-1:0] r_a, r_b, w_a_nx, w_b_nx;
  logic [IW-1:0]    r_idx, w_idx_nx;
  logic             r_decided, w_decided_nx;
  logic             r_a_wins, w_a_wins_nx;
  logic             r_busy, w_busy_nx;
  logic             r_done, w_done_nx;
  logic             r_agt, w_agt_nx;
  logic             r_bgt, w_bgt_nx;
  logic             r_eq, w_eq_nx;

  logic [DIGIT-1:0] w_da, w_db;
  logic             w_dig_gt, w_dig_lt;
  logic             w_first_diff, w_last, w_finish;

  // Operands are shifted left each step, so the current digit is always on top.
  assign w_da = r_a[WIDTH-1 -: DIGIT];
  assign w_db = r_b[WIDTH-1 -: DIGIT];

  // Digit compare; only the most-significant digit carries a sign.
  always_comb begin
    w_dig_gt = (w_da > w_db);
    w_dig_lt = (w_da < w_db);
    if ((SIGNED != 0) && (r_idx == IDX_MSD)) begin
      w_dig_gt = ($signed(w_da) > $signed(w_db));
      w_dig_lt = ($signed(w_da) < $signed(w_db));
    end
  end

  assign w_first_diff = !r_decided && (w_dig_gt || w_dig_lt);
  assign w_last       = (r_idx == '0);

`ifdef MAG_COMP_EARLY_EXIT_EN
  assign w_finish = w_last || w_first_diff;
`else
  assign w_finish = w_last;
`endif

  // Next-state and next-output logic.
  always_comb begin
    w_state_nx   = r_state;
    w_a_nx       = r_a;
    w_b_nx       = r_b;
    w_idx_nx     = r_idx;
    w_decided_nx = r_decided;
    w_a_wins_nx  = r_a_wins;
    w_busy_nx    = r_busy;
    w_done_nx    = 1'b0;
    w_agt_nx     = r_agt;
    w_bgt_nx     = r_bgt;
    w_eq_nx      = r_eq;

    case (r_state)
      ST_IDLE: begin
        if (start) begin
          w_a_nx       = a;
          w_b_nx       = b;
          w_idx_nx     = IDX_MSD;
          w_decided_nx = 1'b0;
          w_a_wins_nx  = 1'b0;
          w_agt_nx     = 1'b0;
          w_bgt_nx     = 1'b0;
          w_eq_nx      = 1'b0;
          w_busy_nx    = 1'b1;
          w_state_nx   = ST_CMP;
        end
      end
      ST_CMP: begin
        // First unequal digit latches the winner; later digits cannot override.
        if (w_first_diff) begin
          w_decided_nx = 1'b1;
          w_a_wins_nx  = w_dig_gt;
        end
        w_a_nx   = r_a << DIGIT;
        w_b_nx   = r_b << DIGIT;
        w_idx_nx = r_idx - IW'(1);
        if (w_finish) begin
          w_idx_nx   = '0;
          w_state_nx = ST_IDLE;
          w_busy_nx  = 1'b0;
          w_done_nx  = 1'b1;
          w_agt_nx   = w_decided_nx && w_a_wins_nx;
          w_bgt_nx   = w_decided_nx && !w_a_wins_nx;
          w_eq_nx    = !w_decided_nx;
        end
      end
      default: w_state_nx = ST_IDLE;
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= ST_IDLE;
      r_a       <= '0;
      r_b       <= '0;
      r_idx     <= '0;
      r_decided <= 1'b0;
      r_a_wins  <= 1'b0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_agt     <= 1'b0;
      r_bgt     <= 1'b0;
      r_eq      <= 1'b0;
    end else begin
      r_state   <= w_state_nx;
      r_a       <= w_a_nx;
      r_b       <= w_b_nx;
      r_idx     <= w_idx_nx;
      r_decided <= w_decided_nx;
      r_a_wins  <= w_a_wins_nx;
      r_busy    <= w_busy_nx;
      r_done    <= w_done_nx;
      r_agt     <= w_agt_nx;
      r_bgt     <= w_bgt_nx;
      r_eq      <= w_eq_nx;
    end
  end

  assign busy       = r_busy;
  assign done       = r_done;
  assign a_greater  = r_agt;
  assign b_greater  = r_bgt;
  assign both_equal = r_eq;

endmodule
